// File: rtl/ysyx_22051145_ifetch.sv
// Instruction fetch unit with a 2-entry instruction FIFO.
//
// Issues in-order 4-byte instruction reads to memory, buffers the returned words and
// presents them to decode together with their address. A redirect (jump_flag) flushes
// the FIFO and moves fetch to jump_addr. Responses still in flight are counted in
// drop_q and discarded when they arrive.
//
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   req_valid/ready/addr       instruction-memory read request (byte address)
//   rsp_valid/data             read response, in request order, always accepted
//   inst_valid/ready/inst/pc   instruction at the FIFO head towards decode
//   jump_flag/jump_addr        redirect pulse and target from execute
//   misalign_err               sticky misaligned-redirect flag
//
// Optional feature: define FETCH_MISALIGN_CHK_EN to flag a misaligned redirect target
// and halt fetching until reset. Without it the target's low two bits are cleared and
// misalign_err is tied to 0.
module ysyx_22051145_ifetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [63:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        jump_flag,
    input  logic [63:0] jump_addr,
    output logic        misalign_err
);

    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic [63:0] head_pc_q, head_pc_d;
    logic [31:0] fifo_q [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [1:0]  outstanding_q, outstanding_d;
    logic [1:0]  drop_q, drop_d;

    logic        pop;
    logic        push;
    logic        req_fire;
    logic        halted;
    logic [2:0]  occupancy;
    logic [63:0] target;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;
    logic bad_jump;

    assign bad_jump     = (jump_addr[1:0] != 2'b00);
    assign halted       = misalign_q;
    assign misalign_err = misalign_q;
`else
    assign halted       = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Targets are always word aligned; a misaligned target is either flagged or truncated.
    assign target = jump_addr & ~64'h3;

    assign inst_valid = (count_q != 2'd0);
    assign inst       = fifo_q[rd_ptr_q];
    assign inst_pc    = head_pc_q;
    assign pop        = inst_valid && inst_ready;

    // Every in-flight request owns a FIFO slot, so the FIFO can never overflow.
    assign occupancy = {1'b0, outstanding_q} + {1'b0, count_q} - {2'b00, pop};
    assign req_valid = !rst && !jump_flag && !halted && (occupancy < 3'd2);
    assign req_addr  = fetch_pc_q;
    assign req_fire  = req_valid && req_ready;

    assign push = rsp_valid && (drop_q == 2'd0) && !jump_flag;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        head_pc_d     = head_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
`ifdef FETCH_MISALIGN_CHK_EN
        misalign_d    = misalign_q;
`endif
        if (jump_flag) begin
            // req_valid is low here, so nothing new joins the in-flight set; a response
            // arriving now is discarded and the rest are dropped as they return.
            fetch_pc_d    = target;
            head_pc_d     = target;
            rd_ptr_d      = 1'b0;
            wr_ptr_d      = 1'b0;
            count_d       = 2'd0;
            outstanding_d = outstanding_q - {1'b0, rsp_valid};
            drop_d        = outstanding_q - {1'b0, rsp_valid};
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_d    = misalign_q | bad_jump;
`endif
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
            end
            outstanding_d = outstanding_q + {1'b0, req_fire} - {1'b0, rsp_valid};
            if (rsp_valid && (drop_q != 2'd0)) begin
                drop_d = drop_q - 2'd1;
            end
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d  = ~rd_ptr_q;
                head_pc_d = head_pc_q + 64'd4;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            head_pc_q     <= RESET_PC;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            outstanding_q <= 2'd0;
            drop_q        <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= 32'd0;
            end
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            head_pc_q     <= head_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            // When full, the write slot equals the head slot; the head is read this cycle
            // before being overwritten, so push and pop together is safe.
            if (push) begin
                fifo_q[wr_ptr_q] <= rsp_data;
            end
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q    <= misalign_d;
`endif
        end
    end

endmodule

// File: tb/tb_ysyx_22051145_ifetch.sv
// Self-checking bench for ysyx_22051145_ifetch: a memory model with configurable
// latency, directed scenarios, and a scoreboard monitor on the decode handshake.
module tb_ysyx_22051145_ifetch;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        jump_flag;
    logic [63:0] jump_addr;
    logic        misalign_err;

    ysyx_22051145_ifetch #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .jump_flag    (jump_flag),
        .jump_addr    (jump_addr),
        .misalign_err (misalign_err)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic [63:0] addr; int due; } pend_t;
    typedef struct { logic [63:0] pc; logic [31:0] word; } exp_t;

    pend_t pend[$];
    exp_t  exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    lat   = 1;
    int    n_req = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_C3C3;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic expect_pc(input logic [63:0] pc);
        exp_q.push_back('{pc: pc, word: mem_word(pc)});
    endtask

    // Wait (bounded) until every expected instruction has been consumed.
    task automatic drain(input string name);
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0 && !inst_valid) break;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory: record accepted requests, answer in order after lat cycles.
    initial forever begin
        @(negedge clk);
        if (!rst && req_valid && req_ready) begin
            pend.push_back('{addr: req_addr, due: cyc + lat});
            n_req++;
        end
    end

    initial begin : mem_rsp
        pend_t p;
        rsp_valid = 1'b0;
        rsp_data  = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            rsp_valid = 1'b0;
            rsp_data  = 32'd0;
            if (rst) begin
                pend.delete();
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                p         = pend.pop_front();
                rsp_valid = 1'b1;
                rsp_data  = mem_word(p.addr);
            end
        end
    end

    // Scoreboard monitor on the decode handshake.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_inst: got pc %h expected none", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_inst_pc", inst_pc, e.pc);
                    chk("mon_inst", {32'd0, inst}, {32'd0, e.word});
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        req_ready  = 1'b0;
        inst_ready = 1'b0;
        jump_flag  = 1'b0;
        jump_addr  = 64'd0;
        lat        = 1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_pc", inst_pc, RESET_PC);
        chk("rst_misalign", 64'(misalign_err), 64'd0);

        // Zero-wait streaming, one instruction per cycle.
        step();
        rst        = 1'b0;
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 10; i++) expect_pc(RESET_PC + 64'(4 * i));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("a_req_valid", 64'(req_valid), 64'd1);
            chk("a_req_addr", req_addr, RESET_PC + 64'(4 * i));
            if (i >= 2) chk("a_inst_valid", 64'(inst_valid), 64'd1);
            step();
        end
        req_ready = 1'b0;
        drain("a_drain");

        // Decode stalled: only two requests may be issued.
        step();
        inst_ready = 1'b0;
        n_req      = 0;
        req_ready  = 1'b1;
        expect_pc(RESET_PC + 64'd40);
        expect_pc(RESET_PC + 64'd44);
        repeat (10) step();
        @(negedge clk);
        chk("b_req_count", 64'(n_req), 64'd2);
        chk("b_req_valid", 64'(req_valid), 64'd0);
        chk("b_inst_valid", 64'(inst_valid), 64'd1);
        step();
        req_ready  = 1'b0;
        inst_ready = 1'b1;
        drain("b_drain");

        // Latency 3, redirect with two requests in flight.
        step();
        lat       = 3;
        req_ready = 1'b1;
        @(negedge clk);
        chk("c_req0_addr", req_addr, RESET_PC + 64'd48);
        step();
        @(negedge clk);
        chk("c_req1_addr", req_addr, RESET_PC + 64'd52);
        chk("c_req1_valid", 64'(req_valid), 64'd1);
        step();
        req_ready = 1'b0;
        jump_flag = 1'b1;
        jump_addr = 64'h0000_0000_8000_0100;
        @(negedge clk);
        chk("c_jump_req_valid", 64'(req_valid), 64'd0);
        step();
        jump_flag = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("c_no_stale", 64'(inst_valid), 64'd0);
        chk("c_resume_valid", 64'(req_valid), 64'd1);
        chk("c_resume_addr", req_addr, 64'h0000_0000_8000_0100);
        expect_pc(64'h0000_0000_8000_0100);
        step();
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        drain("c_drain");

        // Redirect coinciding with a response and a decode handshake.
        step();
        lat       = 1;
        req_ready = 1'b1;
        expect_pc(64'h0000_0000_8000_0104);
        step();
        step();
        jump_flag = 1'b1;
        jump_addr = 64'h0000_0000_8000_0200;
        @(negedge clk);
        chk("d_jump_req_valid", 64'(req_valid), 64'd0);
        chk("d_jump_inst_valid", 64'(inst_valid), 64'd1);
        step();
        jump_flag = 1'b0;
        req_ready = 1'b0;
        @(negedge clk);
        chk("d_fifo_empty", 64'(inst_valid), 64'd0);
        chk("d_req_valid", 64'(req_valid), 64'd1);
        chk("d_req_addr", req_addr, 64'h0000_0000_8000_0200);
        expect_pc(64'h0000_0000_8000_0200);
        step();
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        drain("d_drain");

        // Misaligned redirect target.
        step();
        jump_flag = 1'b1;
        jump_addr = 64'h0000_0000_8000_0102;
        @(negedge clk);
        chk("e_jump_req_valid", 64'(req_valid), 64'd0);
        step();
        jump_flag = 1'b0;
        @(negedge clk);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("e_misalign", 64'(misalign_err), 64'd1);
        chk("e_req_valid", 64'(req_valid), 64'd0);
        step();
        req_ready = 1'b1;
        n_req     = 0;
        repeat (3) step();
        @(negedge clk);
        chk("e_halt_reqs", 64'(n_req), 64'd0);
        chk("e_halt_valid", 64'(req_valid), 64'd0);
        step();
        req_ready = 1'b0;
`else
        chk("e_misalign", 64'(misalign_err), 64'd0);
        chk("e_req_valid", 64'(req_valid), 64'd1);
        chk("e_req_addr", req_addr, 64'h0000_0000_8000_0100);
        expect_pc(64'h0000_0000_8000_0100);
        step();
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        drain("e_drain");
`endif

        // Asynchronous reset in the middle of a burst.
        step();
        lat        = 1;
        req_ready  = 1'b1;
        inst_ready = 1'b0;
        repeat (3) step();
`ifndef FETCH_MISALIGN_CHK_EN
        @(negedge clk);
        chk("f_pre_inst_valid", 64'(inst_valid), 64'd1);
`endif
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("f_rst_req_valid", 64'(req_valid), 64'd0);
        chk("f_rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("f_rst_inst", 64'(inst), 64'd0);
        chk("f_rst_inst_pc", inst_pc, RESET_PC);
        chk("f_rst_misalign", 64'(misalign_err), 64'd0);
        step();
        step();
        rst        = 1'b0;
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_pc(RESET_PC + 64'(4 * i));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("f_req_valid", 64'(req_valid), 64'd1);
            chk("f_req_addr", req_addr, RESET_PC + 64'(4 * i));
            step();
        end
        req_ready = 1'b0;
        drain("f_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
